// File: rtl/period_meter.sv
// Period / high-time / low-time / averaged-period meter for an asynchronous input,
// reporting results in units of CLK_TICK_COUNT clocks with timeout and saturation flags.
module period_meter #(
    parameter int CLK_TICK_COUNT = 50000,
    parameter int T_W            = 16,
    parameter int P_W            = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic           si,
    input  logic [1:0]     mode,
    input  logic [2:0]     navg,
    input  logic [P_W-1:0] tmo,
    output logic           ready,
    output logic           done_tick,
    output logic [P_W-1:0] prd,
    output logic           timeout,
    output logic           ovf
);

    localparam int A_W = P_W + 7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT1 = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [T_W-1:0] T_LAST  = T_W'(CLK_TICK_COUNT - 1);
    localparam logic [A_W-1:0] PRD_MAX = A_W'({P_W{1'b1}});

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    logic [1:0]     state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [2:0]     navg_q, navg_d;
    logic [P_W-1:0] tmo_q, tmo_d;
    logic [T_W-1:0] t_q, t_d;
    logic [A_W-1:0] p_q, p_d;
    logic [6:0]     e_q, e_d;
    logic [P_W-1:0] prd_q, prd_d;
    logic           timeout_q, timeout_d;
    logic           ovf_q, ovf_d;

    logic           s_w, rise_w, fall_w;
    logic           open_w, close_w, last_close_w;
    logic           wrap_w, tmo_hit_w, sat_w;
    logic [T_W-1:0] t_inc_w;
    logic [A_W-1:0] p_inc_w, r_w;
    logic [7:0]     e_plus_w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], si};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_w    = sync_q[SYNC_STAGES-1];
    assign rise_w = ~dly_q & s_w;
    assign fall_w = dly_q & ~s_w;

    assign open_w  = (mode_q == 2'b10) ? fall_w : rise_w;
    assign close_w = (mode_q == 2'b01) ? fall_w : rise_w;

    assign wrap_w  = (t_q == T_LAST);
    assign t_inc_w = wrap_w ? '0 : t_q + 1'b1;
    assign p_inc_w = (p_q == '1) ? p_q : p_q + 1'b1;

    // navg_q is forced to 0 outside averaging mode, so the first closing edge ends those modes.
    assign e_plus_w     = {1'b0, e_q} + 8'd1;
    assign last_close_w = close_w && (e_plus_w == (8'd1 << navg_q));

    assign tmo_hit_w = (tmo_q != '0) && wrap_w && (p_inc_w == A_W'(tmo_q));

    assign r_w   = p_q >> navg_q;
    assign sat_w = (p_q == '1) || (r_w > PRD_MAX);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        navg_d    = navg_q;
        tmo_d     = tmo_q;
        t_d       = t_q;
        p_d       = p_q;
        e_d       = e_q;
        prd_d     = prd_q;
        timeout_d = timeout_q;
        ovf_d     = ovf_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_d  = mode;
                        navg_d  = (mode == 2'b11) ? navg : 3'd0;
                        tmo_d   = tmo;
                        t_d     = '0;
                        p_d     = '0;
                        e_d     = '0;
                        state_d = S_WAIT1;
                    end
                end
                S_WAIT1: begin
                    if (open_w) begin
                        t_d     = '0;
                        p_d     = '0;
                        e_d     = '0;
                        state_d = S_COUNT;
                    end else if (tmo_hit_w) begin
                        prd_d     = '0;
                        ovf_d     = 1'b0;
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        t_d = t_inc_w;
                        if (wrap_w) p_d = p_inc_w;
                    end
                end
                S_COUNT: begin
                    // The ending edge wins over a coincident wrap: that last increment is dropped.
                    if (last_close_w) begin
                        prd_d     = sat_w ? '1 : r_w[P_W-1:0];
                        ovf_d     = sat_w;
                        timeout_d = 1'b0;
                        state_d   = S_DONE;
                    end else if (tmo_hit_w) begin
                        prd_d     = '0;
                        ovf_d     = 1'b0;
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        t_d = t_inc_w;
                        if (wrap_w) p_d = p_inc_w;
                        if (close_w) e_d = e_q + 7'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            navg_q    <= '0;
            tmo_q     <= '0;
            t_q       <= '0;
            p_q       <= '0;
            e_q       <= '0;
            prd_q     <= '0;
            timeout_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            navg_q    <= navg_d;
            tmo_q     <= tmo_d;
            t_q       <= t_d;
            p_q       <= p_d;
            e_q       <= e_d;
            prd_q     <= prd_d;
            timeout_q <= timeout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done_tick = (state_q == S_DONE);
    assign prd       = prd_q;
    assign timeout   = timeout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: two instances (16-bit and 4-bit result) share stimulus and are
// compared against an arithmetic model of the measured interval.
module tb_period_meter;

    localparam int CTC = 10;

    logic        clk = 1'b0;
    logic        reset, start, abort, si;
    logic [1:0]  mode;
    logic [2:0]  navg;
    logic [15:0] tmo;

    logic        ready_a, done_a, to_a, ovf_a;
    logic [15:0] prd_a;
    logic        ready_b, done_b, to_b, ovf_b;
    logic [3:0]  prd_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nd_a = 0, nd_b = 0;
    int done_cyc_a = 0, done_cyc_b = 0;
    bit prev_done_a = 1'b0;

    always #5 clk = ~clk;

    period_meter #(.CLK_TICK_COUNT(CTC), .T_W(8), .P_W(16), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .si(si),
        .mode(mode), .navg(navg), .tmo(tmo),
        .ready(ready_a), .done_tick(done_a), .prd(prd_a), .timeout(to_a), .ovf(ovf_a)
    );

    period_meter #(.CLK_TICK_COUNT(CTC), .T_W(8), .P_W(4), .SYNC_STAGES(3)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .si(si),
        .mode(mode), .navg(navg), .tmo(tmo[3:0]),
        .ready(ready_b), .done_tick(done_b), .prd(prd_b), .timeout(to_b), .ovf(ovf_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_done_a) chk("ready_after_done", 64'(ready_a), 64'd1);
        prev_done_a = done_a;
        if (done_a) begin nd_a++; done_cyc_a = cyc; end
        if (done_b) begin nd_b++; done_cyc_b = cyc; end
    endtask

    // Interval of k clocks from opening to closing edge: every completed unit before
    // the closing cycle counts, i.e. floor((k-1)/CTC), then averaged and clipped.
    function automatic void model(input int k, input int nv, input int pw,
                                  output longint prd_e, output bit ovf_e);
        longint p, accmax, r, maxv;
        p      = longint'((k - 1) / CTC);
        accmax = (longint'(1) << (pw + 7)) - 1;
        maxv   = (longint'(1) << pw) - 1;
        if (p > accmax) p = accmax;
        r = p >> nv;
        if (p == accmax || r > maxv) begin prd_e = maxv; ovf_e = 1'b1; end
        else begin prd_e = r; ovf_e = 1'b0; end
    endfunction

    task automatic measure(input int m, input int nv, input int h, input int l, input bit restart);
        int navg_e, nper, k;
        longint ep_a, ep_b;
        bit eo_a, eo_b;
        navg_e = (m == 3) ? nv : 0;
        nper   = 1 << navg_e;
        case (m)
            0:       k = h + l;
            1:       k = h;
            2:       k = l;
            default: k = nper * (h + l);
        endcase
        si = (m == 2);
        repeat (6) tick();
        nd_a = 0; nd_b = 0;
        mode = 2'(m); navg = 3'(nv); tmo = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode = 2'($urandom); navg = 3'($urandom); tmo = 16'($urandom_range(1, 3));
        repeat ($urandom_range(0, 15)) tick();
        if (m == 2) begin
            si = 1'b0;
            repeat (l) tick();
        end else begin
            for (int i = 0; i < nper; i++) begin
                si = 1'b1;
                start = restart && (i == 0);
                tick();
                start = 1'b0;
                repeat (h - 1) tick();
                si = 1'b0;
                repeat (l) tick();
            end
        end
        si = 1'b1;
        repeat (12) tick();
        tmo = 16'd0;
        model(k, navg_e, 16, ep_a, eo_a);
        model(k, navg_e, 4, ep_b, eo_b);
        chk("done_count_a", 64'(nd_a), 64'd1);
        chk("prd_a", 64'(prd_a), 64'(ep_a));
        chk("ovf_a", 64'(ovf_a), 64'(eo_a));
        chk("timeout_a", 64'(to_a), 64'd0);
        chk("done_count_b", 64'(nd_b), 64'd1);
        chk("prd_b", 64'(prd_b), 64'(ep_b));
        chk("ovf_b", 64'(ovf_b), 64'(eo_b));
        chk("ready_idle", 64'(ready_a), 64'd1);
        $display("meas mode=%0d navg=%0d h=%0d l=%0d k=%0d restart=%0d prd_a=%0d ovf_a=%0d prd_b=%0d ovf_b=%0d exp_a=%0d exp_b=%0d",
                 m, navg_e, h, l, k, restart, prd_a, ovf_a, prd_b, ovf_b, ep_a, ep_b);
    endtask

    task automatic timeout_run(input int tv);
        int start_cyc;
        si = 1'b0;
        repeat (6) tick();
        nd_a = 0; nd_b = 0;
        mode = 2'($urandom); navg = 3'($urandom); tmo = 16'(tv);
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        repeat (tv * CTC + 10) tick();
        tmo = 16'd0;
        chk("tmo_done_count_a", 64'(nd_a), 64'd1);
        chk("tmo_latency_a", 64'(done_cyc_a - start_cyc), 64'(tv * CTC));
        chk("tmo_flag_a", 64'(to_a), 64'd1);
        chk("tmo_prd_a", 64'(prd_a), 64'd0);
        chk("tmo_ovf_a", 64'(ovf_a), 64'd0);
        chk("tmo_done_count_b", 64'(nd_b), 64'd1);
        chk("tmo_flag_b", 64'(to_b), 64'd1);
        chk("tmo_prd_b", 64'(prd_b), 64'd0);
        $display("timeout tmo=%0d latency=%0d timeout_a=%0d prd_a=%0d", tv, done_cyc_a - start_cyc, to_a, prd_a);
    endtask

    // Start a period measurement, let it get into counting, and return mid-count.
    task automatic start_and_count();
        si = 1'b0;
        repeat (6) tick();
        nd_a = 0; nd_b = 0;
        mode = 2'b00; navg = 3'd0; tmo = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        si = 1'b1;
        repeat (40) tick();
    endtask

    initial begin
        int m, nv, h, l;
        reset = 1'b0; start = 1'b0; abort = 1'b0; si = 1'b0;
        mode = '0; navg = '0; tmo = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_prd", 64'(prd_a), 64'd0);
        chk("rst_ready", 64'(ready_a), 64'd1);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_timeout", 64'(to_a), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
        reset = 1'b1;
        $display("reset released prd=%0d ready=%0d", prd_a, ready_a);

        measure(0, 0, 100, 155, 1'b0);
        measure(1, 0, 75, 180, 1'b0);
        measure(2, 0, 75, 180, 1'b0);
        measure(3, 2, 100, 155, 1'b0);
        timeout_run(5);
        measure(0, 0, 100, 155, 1'b1);

        start_and_count();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ready", 64'(ready_a), 64'd1);
        si = 1'b0;
        repeat (155) tick();
        si = 1'b1;
        repeat (12) tick();
        chk("abort_no_done_a", 64'(nd_a), 64'd0);
        chk("abort_no_done_b", 64'(nd_b), 64'd0);
        chk("abort_prd_held_a", 64'(prd_a), 64'd25);
        chk("abort_prd_held_b", 64'(prd_b), 64'd15);
        $display("abort mid-count done=%0d prd_a=%0d prd_b=%0d", nd_a, prd_a, prd_b);

        si = 1'b0;
        repeat (6) tick();
        nd_a = 0;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 64'(ready_a), 64'd1);
        si = 1'b1;
        repeat (20) tick();
        chk("start_abort_no_done", 64'(nd_a), 64'd0);
        $display("start+abort in idle ready=%0d done=%0d", ready_a, nd_a);

        start_and_count();
        reset = 1'b0;
        #1;
        chk("midrst_prd", 64'(prd_a), 64'd0);
        chk("midrst_ready", 64'(ready_a), 64'd1);
        chk("midrst_ovf_b", 64'(ovf_b), 64'd0);
        tick();
        reset = 1'b1;
        si = 1'b0;
        repeat (155) tick();
        si = 1'b1;
        repeat (12) tick();
        chk("midrst_no_done", 64'(nd_a), 64'd0);
        $display("reset mid-count prd_a=%0d ready=%0d done=%0d", prd_a, ready_a, nd_a);

        for (int it = 0; it < 12; it++) begin
            m  = int'($urandom_range(0, 3));
            nv = int'($urandom_range(0, 3));
            h  = int'($urandom_range(3, (m == 3) ? 60 : 150));
            l  = int'($urandom_range(3, (m == 3) ? 60 : 150));
            measure(m, nv, h, l, 1'($urandom_range(0, 1)));
        end
        timeout_run(int'($urandom_range(1, 4)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
